sram_arbiter: RTL and testbench

Arbitrates the single external 32-bit asynchronous SRAM between the CPU's instruction-fetch port and data-memory port. Generates the SRAM strobe sequence and returns per-port acknowledges so the pipeline can stall. Sits between `CPU` and the board SRAM pins, replacing the ideal single-cycle memories used in pure simulation.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_seq.sv | 114 +++++++++++
 rtl/sram_arbiter.sv | 97 +++++++++
 tb/tb_sram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: sequencer states, grant encoding, default width.
// Under SRAM_WAIT_EN the sequencer gains the S_RD_WAIT state.
package sram_arb_pkg;

  localparam int SRAM_AW_DEFAULT = 20;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
`ifdef SRAM_WAIT_EN
    , S_RD_WAIT
`endif
  } seq_state_e;

endpackage

// File: rtl/sram_seq.sv
// Strobe sequencer for one asynchronous SRAM access; latches the command at start.
// SRAM_WAIT_EN adds a read wait state and stretches the write pulse to two cycles.
module sram_seq
  import sram_arb_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SRAM_AW-1:0] cmd_addr,
  input  logic               cmd_we,
  input  logic [3:0]         cmd_be,
  input  logic [31:0]        cmd_wdata,
  output logic               idle,
  output logic               done,
  output logic [31:0]        rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  seq_state_e state;
`ifdef SRAM_WAIT_EN
  logic pulse_2nd;
`endif

  assign idle = (state == S_IDLE);

  // Every pin is driven from a flop so the SRAM never sees combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_dq_oe <= 1'b0;
`ifdef SRAM_WAIT_EN
      pulse_2nd  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sram_addr <= cmd_addr;
            sram_ce_n <= 1'b0;
            if (cmd_we) begin
              sram_be_n  <= ~cmd_be;
              sram_dq_oe <= 1'b1;
              state      <= S_WR_SETUP;
            end else begin
              sram_be_n <= 4'h0;
              sram_oe_n <= 1'b0;
              state     <= S_RD;
            end
          end
        end
        S_RD: begin
`ifdef SRAM_WAIT_EN
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
`endif
          rdata     <= sram_dq_i;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_be_n <= 4'hF;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_WR_SETUP: begin
          sram_we_n <= 1'b0;
          state     <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
`ifdef SRAM_WAIT_EN
          pulse_2nd <= ~pulse_2nd;
          if (pulse_2nd) begin
`else
          begin
`endif
            sram_we_n <= 1'b1;
            state     <= S_WR_HOLD;
          end
        end
        S_WR_HOLD: begin
          sram_ce_n  <= 1'b1;
          sram_be_n  <= 4'hF;
          sram_dq_oe <= 1'b0;
          done       <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write data is pure datapath; it is only observed while sram_dq_oe is high.
  always_ff @(posedge clk) begin
    if (start && state == S_IDLE) sram_dq_o <= cmd_wdata;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM between the instruction-fetch and data ports.
// Define SRAM_WAIT_EN for slow parts: one extra read cycle and a two-cycle write pulse.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ack,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [3:0]         mem_be,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ack,
  output logic               stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  gnt_e               gnt;
  logic               gnt_we;
  logic               pick_mem;
  logic               start;
  logic               seq_idle;
  logic               seq_done;
  logic [31:0]        seq_rdata;
  logic [31:0]        if_hold;
  logic [31:0]        mem_hold;
  logic [SRAM_AW-1:0] cmd_addr;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                              mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

  // gnt doubles as the last-grant flag: a pending fetch beats data right after a data grant.
  assign pick_mem = mem_req & ~(if_req & (gnt == GNT_MEM));
  assign start    = seq_idle & (if_req | mem_req);
  assign cmd_addr = pick_mem ? mem_addr[SRAM_AW+1:2] : if_addr[SRAM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= GNT_IF;
      gnt_we   <= 1'b0;
      if_hold  <= '0;
      mem_hold <= '0;
    end else begin
      if (start) begin
        gnt    <= pick_mem ? GNT_MEM : GNT_IF;
        gnt_we <= pick_mem & mem_we;
      end
      if (if_ack)            if_hold  <= seq_rdata;
      if (mem_ack & ~gnt_we) mem_hold <= seq_rdata;
    end
  end

  assign if_ack    = seq_done & (gnt == GNT_IF);
  assign mem_ack   = seq_done & (gnt == GNT_MEM);
  assign if_rdata  = if_ack ? seq_rdata : if_hold;
  assign mem_rdata = (mem_ack & ~gnt_we) ? seq_rdata : mem_hold;
  assign stall     = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  sram_seq #(
    .SRAM_AW (SRAM_AW)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cmd_addr   (cmd_addr),
    .cmd_we     (pick_mem & mem_we),
    .cmd_be     (mem_be),
    .cmd_wdata  (mem_wdata),
    .idle       (seq_idle),
    .done       (seq_done),
    .rdata      (seq_rdata),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_be_n  (sram_be_n)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, transaction-level scoreboard, directed and mixed traffic.
// Honours SRAM_WAIT_EN so the same bench covers both timing variants.
module tb_sram_arbiter;

  localparam int AW = 20;
`ifdef SRAM_WAIT_EN
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 5;
  localparam int PULSE_LEN = 2;
`else
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 4;
  localparam int PULSE_LEN = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [3:0]    mem_be = 4'h0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          stall;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o;
  logic          sram_dq_oe;
  logic [31:0]   sram_dq_i;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] sram    [0:255];
  logic [31:0] exp_mem [0:255];

  sram_arbiter #(.SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous SRAM: reads while ce/oe low, a write commits when we_n rises with ce still low.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n && !sram_dq_oe) ? sram[sram_addr[7:0]] : 32'hDEAD_BEEF;

  logic we_seen = 1'b0;
  always @(negedge clk) begin
    if (rst) we_seen = 1'b0;
    else if (!sram_we_n) we_seen = 1'b1;
    else if (we_seen) begin
      we_seen = 1'b0;
      if (!sram_ce_n && sram_dq_oe)
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) sram[sram_addr[7:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
    end
  end

  // Scoreboard: one access at a time, granted when free, acked a fixed latency later.
  logic          m_busy = 1'b0, m_gnt_mem = 1'b0, m_last_mem = 1'b0, m_we = 1'b0;
  logic [3:0]    m_be = '0;
  logic [31:0]   m_wdata = '0, m_rd = '0, m_ifr = '0, m_memr = '0;
  logic [AW-1:0] m_addr = '0;
  int            m_gcyc = 0, m_acyc = 0;

  always @(negedge clk) begin
    logic was_busy, e_if, e_mem, active;
    if (rst) begin
      m_busy = 1'b0; m_last_mem = 1'b0; m_ifr = '0; m_memr = '0;
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_mem_ack", mem_ack, 1'b0);
      chk1("rst_ce_n", sram_ce_n, 1'b1);
      chk1("rst_oe_n", sram_oe_n, 1'b1);
      chk1("rst_we_n", sram_we_n, 1'b1);
      chk1("rst_dq_oe", sram_dq_oe, 1'b0);
      chk32("rst_sram_addr", {12'h0, sram_addr}, 32'h0);
      chk32("rst_if_rdata", if_rdata, 32'h0);
      chk32("rst_mem_rdata", mem_rdata, 32'h0);
    end else begin
      was_busy = m_busy;
      e_if   = m_busy && cyc == m_acyc && !m_gnt_mem;
      e_mem  = m_busy && cyc == m_acyc && m_gnt_mem;
      active = m_busy && cyc > m_gcyc && cyc < m_acyc;
      chk1("if_ack", if_ack, e_if);
      chk1("mem_ack", mem_ack, e_mem);
      chk1("stall", stall, (if_req & ~e_if) | (mem_req & ~e_mem));
      chk1("oe_with_dq_oe", !sram_oe_n && sram_dq_oe, 1'b0);
      if (active) begin
        chk1("ce_n_active", sram_ce_n, 1'b0);
        chk32("sram_addr", {12'h0, sram_addr}, {12'h0, m_addr});
        if (m_we) begin
          chk32("be_n_wr", {28'h0, sram_be_n}, {28'h0, ~m_be});
          chk1("dq_oe_wr", sram_dq_oe, 1'b1);
          chk1("oe_n_wr", sram_oe_n, 1'b1);
          chk32("dq_o", sram_dq_o, m_wdata);
          chk1("we_n_wr", sram_we_n, !(cyc >= m_gcyc + 2 && cyc <= m_gcyc + 1 + PULSE_LEN));
        end else begin
          chk32("be_n_rd", {28'h0, sram_be_n}, 32'h0);
          chk1("oe_n_rd", sram_oe_n, 1'b0);
          chk1("we_n_rd", sram_we_n, 1'b1);
          chk1("dq_oe_rd", sram_dq_oe, 1'b0);
        end
      end else begin
        chk1("ce_n_idle", sram_ce_n, 1'b1);
        chk1("oe_n_idle", sram_oe_n, 1'b1);
        chk1("we_n_idle", sram_we_n, 1'b1);
        chk1("dq_oe_idle", sram_dq_oe, 1'b0);
      end
      if (e_if) m_ifr = m_rd;
      if (e_mem && !m_we) m_memr = m_rd;
      if (e_mem && m_we)
        for (int b = 0; b < 4; b++)
          if (m_be[b]) exp_mem[m_addr[7:0]][8*b +: 8] = m_wdata[8*b +: 8];
      chk32("if_rdata", if_rdata, m_ifr);
      chk32("mem_rdata", mem_rdata, m_memr);
      if (m_busy && cyc == m_acyc) m_busy = 1'b0;
      if (!was_busy && (if_req || mem_req)) begin
        m_gnt_mem  = mem_req && !(if_req && m_last_mem);
        m_last_mem = m_gnt_mem;
        m_we    = m_gnt_mem && mem_we;
        m_be    = mem_be;
        m_wdata = mem_wdata;
        m_addr  = m_gnt_mem ? mem_addr[AW+1:2] : if_addr[AW+1:2];
        m_rd    = exp_mem[m_addr[7:0]];
        m_busy  = 1'b1;
        m_gcyc  = cyc;
        m_acyc  = cyc + (m_we ? WR_LAT : RD_LAT);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, ack_at, we_low, nacks;
    logic ord [4];
    int ackc [4];

    for (int i = 0; i < 256; i++) sram[i] = 32'hA5A5_0000 | 32'(i);
    sram[4]    = 32'h2402_0005;
    sram[32]   = 32'h5566_7788;
    sram[64]   = 32'h1122_3344;
    for (int i = 0; i < 256; i++) exp_mem[i] = sram[i];

    repeat (3) @(posedge clk);
    #1;
    chk1("reset_we_n", sram_we_n, 1'b1);
    rst = 1'b0;

    // Reset in the middle of a write pulse.
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 32'h80; mem_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk1("t1_setup_dq_oe", sram_dq_oe, 1'b1);
    chk1("t1_setup_we_n", sram_we_n, 1'b1);
    @(posedge clk); #1;
    chk1("t1_pulse_we_n", sram_we_n, 1'b0);
    rst = 1'b1; mem_req = 1'b0;
    #1;
    chk1("t1_rst_we_n", sram_we_n, 1'b1);
    chk1("t1_rst_dq_oe", sram_dq_oe, 1'b0);
    chk1("t1_rst_mem_ack", mem_ack, 1'b0);
    chk1("t1_rst_if_ack", if_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk32("t1_word_kept", sram[32], 32'h5566_7788);

    // Instruction fetch from word 4.
    if_req = 1'b1; if_addr = 32'h10;
    @(posedge clk); #1;
    chk32("t2_sram_addr", {12'h0, sram_addr}, 32'h4);
    repeat (RD_LAT - 1) begin @(posedge clk); #1; end
    chk1("t2_if_ack", if_ack, 1'b1);
    chk32("t2_if_rdata", if_rdata, 32'h2402_0005);
    if_req = 1'b0; if_addr = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    chk1("t2_if_ack_low", if_ack, 1'b0);
    chk32("t2_if_rdata_held", if_rdata, 32'h2402_0005);

    // Byte-lane write; inputs are scrambled after grant to prove they were latched.
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0010; mem_addr = 32'h100; mem_wdata = 32'h0000_AB00;
    t0 = cyc; ack_at = -1; we_low = 0;
    for (int k = 0; k < 20 && ack_at < 0; k++) begin
      @(posedge clk); #1;
      if (cyc - t0 == 1) begin
        chk32("t3_be_n", {28'h0, sram_be_n}, 32'hD);
        mem_be = 4'hF; mem_wdata = 32'hFFFF_FFFF; mem_addr = 32'h0;
      end
      if (!sram_we_n) we_low++;
      if (mem_ack) ack_at = cyc - t0;
    end
    mem_req = 1'b0; mem_we = 1'b0;
    chki("t3_ack_cycle", ack_at, WR_LAT);
    chki("t3_we_low_cycles", we_low, PULSE_LEN);
    chk32("t3_sram_word", sram[64], 32'h1122_AB44);

    // Simultaneous held requests after reset: grants alternate starting with data.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; if_req = 1'b1; if_addr = 32'h30;
    t0 = cyc; nacks = 0;
    for (int k = 0; k < 4; k++) begin ord[k] = 1'bx; ackc[k] = -1; end
    for (int k = 0; k < 60 && nacks < 4; k++) begin
      @(posedge clk); #1;
      chk1("t4_both_acks", if_ack & mem_ack, 1'b0);
      if (if_ack || mem_ack) begin
        ord[nacks] = mem_ack; ackc[nacks] = cyc - t0; nacks++;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chki("t4_ack_count", nacks, 4);
    chk1("t4_grant0_mem", ord[0], 1'b1);
    chk1("t4_grant1_if", ord[1], 1'b0);
    chk1("t4_grant2_mem", ord[2], 1'b1);
    chk1("t4_grant3_if", ord[3], 1'b0);
    for (int k = 0; k < 4; k++) chki("t4_ack_cycle", ackc[k], (k + 1) * (RD_LAT + 1) - 1);

    // Mixed concurrent traffic against the scoreboard.
    fork
      begin : if_stream
        logic got_i;
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          @(posedge clk); #1;
          if_req = 1'b1; if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          got_i = 1'b0;
          for (int n = 0; n < 40 && !got_i; n++) begin @(posedge clk); #1; got_i = if_ack; end
          chk1("t5_if_ack_seen", got_i, 1'b1);
          if_req = 1'b0; if_addr = $urandom;
        end
      end
      begin : mem_stream
        logic got_m;
        for (int k = 0; k < 12; k++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          @(posedge clk); #1;
          mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1)); mem_be = 4'($urandom_range(1, 15));
          mem_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00}; mem_wdata = $urandom;
          got_m = 1'b0;
          for (int n = 0; n < 40 && !got_m; n++) begin @(posedge clk); #1; got_m = mem_ack; end
          chk1("t5_mem_ack_seen", got_m, 1'b1);
          mem_req = 1'b0; mem_wdata = $urandom;
        end
      end
    join

    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) chk32("final_sram_word", sram[i], exp_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
